// File: rtl/lsmitll_merget_sync_if.sv
// Pulse-stream bundle for the merger emulation model: two toggle-encoded inputs,
// the merged toggle output and the timing-violation status signals.
interface lsmitll_merget_sync_if #(
  parameter int ERRW = 8
);
  logic            a;
  logic            b;
  logic            q;
  logic            busy;
  logic            err;
  logic [ERRW-1:0] err_cnt;

  modport master (output a, b, input q, busy, err, err_cnt);
  modport slave  (input a, b, output q, busy, err, err_cnt);
endinterface

// File: rtl/lsmitll_merget_sync.sv
// Cycle-based RSFQ merger: recombines two toggle-encoded pulse streams with a fixed
// latency and a critical-timing window. Optional X-propagation: LSMITLL_MERGET_XPROP_EN.
module lsmitll_merget_sync #(
  parameter int DELAY = 3,
  parameter int CT    = 4,
  parameter int ERRW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  lsmitll_merget_sync_if.slave bus
);
  localparam int CW = (CT > 0) ? $clog2(CT + 1) : 1;

  logic             a_d;
  logic             b_d;
  logic [DELAY-1:0] pipe;
  logic [CW-1:0]    win;
  logic             q_r;
  logic             err_r;
  logic [ERRW-1:0]  cnt_r;

  logic pa;
  logic pb;
  logic busy;
  logic accept;
  logic viol;

  assign pa     = bus.a ^ a_d;
  assign pb     = bus.b ^ b_d;
  assign busy   = (win != '0);
  assign accept = (pa | pb) & ~busy;
  // A coincident pair is a violation whether or not the window is open; counted once.
  assign viol   = ((pa | pb) & busy) | (pa & pb);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_d   <= bus.a;
      b_d   <= bus.b;
      pipe  <= '0;
      win   <= '0;
      err_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      a_d <= bus.a;
      b_d <= bus.b;
      for (int i = DELAY - 1; i > 0; i--) begin
        pipe[i] <= pipe[i-1];
      end
      pipe[0] <= accept;
      if (accept) begin
        win <= CW'(CT);
      end else if (busy) begin
        win <= win - CW'(1);
      end
      err_r <= viol;
      if (viol && (cnt_r != '1)) begin
        cnt_r <= cnt_r + ERRW'(1);
      end
    end
  end

`ifdef LSMITLL_MERGET_XPROP_EN
  logic x_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= 1'b0;
      x_lock <= 1'b0;
    end else if (viol || x_lock) begin
      q_r    <= 1'bx;
      x_lock <= 1'b1;
    end else begin
      q_r <= q_r ^ pipe[DELAY-1];
    end
  end

  always @(posedge clk) begin
    if (!rst && viol) begin
      $display("Violation of critical timing in module %m; %0t ps.", $time);
    end
  end
`else
  // The oldest pipeline stage carries the pulse accepted DELAY edges ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 1'b0;
    end else begin
      q_r <= q_r ^ pipe[DELAY-1];
    end
  end
`endif

  assign bus.q       = q_r;
  assign bus.busy    = busy;
  assign bus.err     = err_r;
  assign bus.err_cnt = cnt_r;
endmodule
